// File: rtl/div_unit.sv
// div_unit: iterative 32-bit MIPS DIV/DIVU unit in the execute stage.
// Restoring radix-2 division, one quotient bit per cycle (32 CALC cycles),
// then a single DONE cycle presenting LO (quotient) and HI (remainder).
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      DIV/DIVU held in EX (level)
//   signed_i     1 = DIV, 0 = DIVU; sampled with start_i
//   dividend_i   rs operand; sampled with start_i
//   divisor_i    rt operand; sampled with start_i
//   flush_i      kills the EX instruction, aborts any division
//   stall_o      to stall controller ex_stall_i (combinational)
//   done_o       one-cycle pulse, results valid
//   quotient_o   quotient, written to LO
//   remainder_o  remainder, written to HI
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [31:0] dvd_raw;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic [31:0] dvd_mag;
    logic [31:0] dsr_mag;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] q_signed;
    logic [31:0] r_signed;

    // Operand magnitudes; 0x8000_0000 maps to itself, which is the correct
    // unsigned magnitude.
    always_comb begin
        dvd_mag = (signed_i && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
        dsr_mag = (signed_i && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;
    end

    // One restoring step. The trial is kept 34 bits wide so its sign bit is
    // exact even when the shifted remainder exceeds 2^32.
    always_comb begin
        shifted  = {rem[31:0], quo[31]};
        trial    = {1'b0, shifted} - {2'b00, dsr};
        rem_nx   = trial[33] ? shifted : trial[32:0];
        quo_nx   = {quo[30:0], ~trial[33]};
        q_signed = neg_q ? (32'd0 - quo_nx) : quo_nx;
        r_signed = neg_r ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall_o  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = CALC;
                end
                stall_o = start_i;
            end
            CALC: begin
                if (cnt == 6'd31) begin
                    state_nx = DONE;
                end
                stall_o = 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (flush_i) begin
            state_nx = IDLE;
            stall_o  = 1'b0;
        end
        // Release the pipeline while reset is asserted, even if start_i is high.
        if (!rst_n) begin
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_zero    <= 1'b0;
            done_o      <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            cnt      <= '0;
                            rem      <= '0;
                            quo      <= dvd_mag;
                            dsr      <= dsr_mag;
                            dvd_raw  <= dividend_i;
                            neg_q    <= signed_i & (dividend_i[31] ^ divisor_i[31]);
                            neg_r    <= signed_i & dividend_i[31];
                            div_zero <= (divisor_i == 32'd0);
                        end
                    end
                    CALC: begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 6'd1;
                        // Results are registered on the final step so they
                        // and done_o are valid throughout the DONE cycle.
                        if (cnt == 6'd31) begin
                            done_o      <= 1'b1;
                            quotient_o  <= div_zero ? '1 : q_signed;
                            remainder_o <= div_zero ? dvd_raw : r_signed;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit MIPS DIV/DIVU unit in the execute stage. It drives the `ex_stall_i` input of the pipeline stall controller, holding the front of the pipeline while a division runs. It accepts a division request from the instruction sitting in EX and performs a restoring radix-2 division, one quotient bit per cycle. It then presents quotient (LO) and remainder (HI) for one completion cycle, during which it releases the stall.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  EX holds a DIV/DIVU instruction; level signal, stays high while that instruction is held in EX.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- dividend_i  in  32  rs operand; sampled with start_i.
- divisor_i  in  32  rt operand; sampled with start_i.
- flush_i  in  1  exception or redirect kills the EX instruction; aborts any division.
- stall_o  out  1  feeds stall controller `ex_stall_i`.
- done_o  out  1  one-cycle pulse; quotient_o and remainder_o are valid for HI/LO write.
- quotient_o  out  32  quotient, written to LO.
- remainder_o  out  32  remainder, written to HI.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, 6-bit iteration counter = 0, quotient_o = 0, remainder_o = 0, done_o = 0.
- IDLE:
  - If start_i & ~flush_i, latch the operands:
    - |dividend| and |divisor|. Magnitudes are taken only when signed_i = 1; otherwise the raw values are used.
    - neg_q = signed_i & (dividend[31] ^ divisor[31]).
    - neg_r = signed_i & dividend[31].
    - Raw dividend, kept for the divide-by-zero case.
  - Clear the counter and go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1; trial = rem[32:0] − {1'b0, divisor}.
  - If trial is non-negative: rem = trial, quo[0] = 1; else quo[0] = 0.
  - Remainder register is 33 bits wide.
  - After the 32nd iteration (counter == 31), go to DONE.
- DONE:
  - quotient_o = neg_q ? −quo : quo.
  - remainder_o = neg_r ? −rem[31:0] : rem[31:0].
  - done_o = 1. Go to IDLE next cycle unconditionally.
  - start_i is ignored in this cycle, because the same instruction is still in EX as it leaves.
- Divide by zero:
  - Full latency still applies.
  - quotient_o = 32'hFFFF_FFFF and remainder_o = raw dividend_i, for both signed and unsigned.
- Signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0. This falls out of the magnitude path and needs no special case.
- quotient_o and remainder_o hold their last values until the next DONE.
- flush_i:
  - From any state, the next state is IDLE.
  - No done_o pulse, outputs unchanged, counter cleared.
  - In IDLE, flush_i has priority over start_i.

## Timing
- stall_o = ~flush_i & ((IDLE & start_i) | CALC). This is combinational so the request cycle itself stalls.
- Request accepted at cycle T. CALC occupies T+1 … T+32. DONE is at T+33.
- stall_o is high for T … T+32 (33 cycles) and low at T+33.
- done_o and results are valid at T+33 and are registered outputs.
- A new DIV arriving in EX at T+34 or later starts a fresh operation; there is no back-to-back restart from DONE.
- Reset asserted mid-operation: immediate return to IDLE and all outputs to reset values. No done_o after release.

## Test plan
- Unsigned basic: DIVU 100 / 7 at T → stall_o high T…T+32; at T+33 done_o = 1, quotient_o = 14, remainder_o = 2; IDLE at T+34.
- Signed: DIV 0xFFFF_FFF9 (−7) / 2 → quotient_o = 0xFFFF_FFFD (−3), remainder_o = 0xFFFF_FFFF (−1). DIV 7 / 0xFFFF_FFFE → quotient 0xFFFF_FFFD, remainder 1.
- Corners:
  - DIVU 5 / 0 → quotient_o = 0xFFFF_FFFF, remainder_o = 5 at T+33.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0.
  - DIVU 0xFFFF_FFFF / 1 → quotient 0xFFFF_FFFF, remainder 0.
- Flush: start at T, flush_i at T+10 → stall_o low at T+10, IDLE at T+11, no done_o, outputs keep previous values. flush_i together with start_i in IDLE → no start.
- Held start: start_i kept high through DONE at T+33 and deasserted at T+34 → exactly one done_o pulse. A second DIV with start at T+35 completes at T+68.
- Reset: rst_n low at T+15 asynchronously → done_o = 0, outputs = 0, stall_o = 0 immediately. After release, start_i low → remains idle.
